uart_rx: RTL

//  8-N-1 asynchronous serial receiver; counterpart of the core's uart_tx, same clock domain (high_clk).

---
 rtl/uart_rx.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: 16x oversampling, mid-bit majority vote, 1-entry holding register.
// Define UART_RX_PARITY_EN for 8-E/O-1 framing with an rx_parity_err pulse.
module uart_rx #(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       rx_parity_err
`endif
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HI
  } state_t;

  state_t        state_q, state_d;
  logic          meta_q, meta_d, rxs_q, rxs_d;
  logic [1:0]    fill_q, fill_d;
  logic          line_hi_q, line_hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
  logic          perr_q, perr_d;
  logic          par_q, par_d;
  logic          tick, decide, bit_end, maj, par_ok, commit;

  always_comb begin
    state_d   = state_q;
    meta_d    = rx;
    rxs_d     = meta_q;
    fill_d    = {fill_q[0], 1'b1};
    // Only a genuine high-to-low transition of the real line arms a start.
    line_hi_d = fill_q[1] & rxs_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    bit_d     = bit_q;
    smp_d     = smp_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    par_d     = par_q;
    commit    = 1'b0;

    tick    = (cnt_q == CW'(DIV - 1));
    decide  = tick && (s_q == SW'(8));
    bit_end = tick && (s_q == SW'(OVERSAMPLE - 1));
    maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q)
            | (smp_q[1] & rxs_q);
`ifdef UART_RX_PARITY_EN
    par_ok  = ((^{sh_q, par_q}) == PARITY_ODD);
`else
    par_ok  = 1'b1;
`endif

    cnt_d = tick ? '0 : cnt_q + CW'(1);
    if (tick) s_d = bit_end ? '0 : s_q + SW'(1);
    if (tick && s_q == SW'(6)) smp_d[0] = rxs_q;
    if (tick && s_q == SW'(7)) smp_d[1] = rxs_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        s_d   = '0;
        if (line_hi_q && !rxs_q) state_d = START;
      end
      START: begin
        if (decide && maj) state_d = IDLE;
        else if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (decide) sh_d = {maj, sh_q[7:1]};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) par_d = maj;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (decide) begin
          perr_d = ~par_ok;
          if (maj) begin
            state_d = IDLE;
            commit  = par_ok;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        cnt_d = '0;
        s_d   = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (commit) begin
      valid_d = 1'b1;
      data_d  = sh_q;
      if (valid_q && !rx_ack) ovr_d = 1'b1;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      meta_q    <= 1'b1;
      rxs_q     <= 1'b1;
      fill_q    <= '0;
      line_hi_q <= 1'b0;
      cnt_q     <= '0;
      s_q       <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      par_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      meta_q    <= meta_d;
      rxs_q     <= rxs_d;
      fill_q    <= fill_d;
      line_hi_q <= line_hi_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      par_q     <= par_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  logic unused_par;
  assign unused_par = perr_q ^ par_q;
`endif

endmodule
